halt_ctrl: RTL
==============

Name: halt_ctrl

Overview:
- Core-side producer of the simulation halt handshake.
- Sits between the writeback stage and the DPI-C harness.
- When an ebreak commits, it stalls the pipeline and waits for outstanding memory traffic to drain. It then presents a valid/ready halt request carrying the exit code (a0 low 32 bits) and the ebreak PC.
- The harness consumes the request and ends the run. The core stays frozen afterwards.

Parameters:
- XLEN, 64, register/PC width.
- DRAIN_CYCLES, 2, minimum cycles to hold stall after the ebreak commits before requesting halt (0 allowed).
- WDOG_LIMIT, 100000, watchdog cycle limit (used only with HALT_WATCHDOG_EN).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- wb_valid  input  1  an instruction commits this cycle.
- wb_inst  input  32  committing instruction word.
- wb_pc  input  XLEN  committing PC.
- R10  input  XLEN  current a0 from the register file.
- lsu_busy  input  1  a store or load is still outstanding.
- stall_o  output  1  freeze fetch/decode/execute; suppress younger commits.
- halt_valid  output  1  halt request valid.
- halt_ready  input  1  harness accepts the request.
- halt_code  output  32  exit code.
- halt_pc  output  XLEN  PC of the halting instruction.
- halted  output  1  halt accepted; core permanently frozen.

Behaviour:
- Reset (sync, active-high, overrides any state): state=RUN; halt_valid=0, halted=0, halt_code=0, halt_pc=0, drain counter=0. stall_o deasserts in the cycle after reset is sampled.
- ebreak_hit = wb_valid && wb_inst==32'h00100073 && state==RUN.
- States:
  - RUN: stall_o = ebreak_hit (combinational, same cycle).
    - On ebreak_hit: latch halt_code<=R10[31:0], halt_pc<=wb_pc, cnt<=DRAIN_CYCLES, go to DRAIN.
  - DRAIN: stall_o=1.
    - cnt decrements by 1 per cycle while cnt!=0, regardless of lsu_busy.
    - Leave for REQ in the first cycle where cnt==0 && !lsu_busy.
    - With DRAIN_CYCLES=0 and lsu_busy=0, REQ is entered the cycle after ebreak_hit.
    - lsu_busy stuck high: DRAIN is held indefinitely (watchdog excepted).
  - REQ: stall_o=1, halt_valid=1. halt_code and halt_pc are held stable.
    - On halt_valid && halt_ready: go to HALTED next cycle.
    - halt_valid must not drop before acceptance.
  - HALTED: stall_o=1, halted=1, halt_valid=0. The state is terminal until reset.
- Latency: with lsu_busy=0 and halt_ready tied high, halted asserts DRAIN_CYCLES+2 cycles after the ebreak commit cycle.
- wb_valid in any state other than RUN is ignored; no recapture occurs.
- halt_ready asserted outside REQ has no effect.
- Non-ebreak SYSTEM instructions (e.g. ecall 0x00000073) do not trigger a halt.
- halt_code is R10 truncated to bits [31:0]; no sign handling.

Optional Feature:
- HALT_WATCHDOG_EN defined:
  - A 32-bit counter increments each RUN cycle with wb_valid=0 and clears on any wb_valid.
  - When the counter reaches WDOG_LIMIT-1 in RUN without an ebreak_hit: latch halt_code<=32'hFFFF_FFFF and halt_pc<=last committed PC (0 if none), then go directly to REQ, skipping DRAIN.
  - If ebreak_hit and expiry occur in the same cycle, ebreak wins.
- HALT_WATCHDOG_EN undefined: no counter logic; a hung core never halts.

Decomposition:
- Shared package halt_pkg contains:
  - state enum {RUN, DRAIN, REQ, HALTED}
  - EBREAK_INST = 32'h00100073
  - WDOG_HALT_CODE = 32'hFFFF_FFFF
- One sub-module, halt_watchdog (counter + expiry pulse), is instantiated only under HALT_WATCHDOG_EN.

Test Plan:
- Commit ebreak with R10=0x0000_0000_0000_0000, lsu_busy=0, halt_ready=1 -> halt_valid rises at cycle+3 (DRAIN_CYCLES=2); halt_code=0, halt_pc=commit PC; halted at cycle+4.
- Commit ebreak with R10=0xABCD_1234_0000_0007, lsu_busy high for 5 cycles -> halt_valid asserts only after lsu_busy falls; halt_code=0x0000_0007.
- In REQ, hold halt_ready=0 for 10 cycles while toggling R10 and wb_valid -> halt_valid, halt_code and halt_pc stay stable; accepted on the first cycle halt_ready=1.
- Commit ecall (0x00000073), then a further wb_valid commit -> state stays RUN, stall_o=0, no halt.
- Assert reset in the DRAIN state, then commit ebreak with R10=1 -> all outputs clear in the cycle after reset; the later ebreak halts normally with code 1.
- With HALT_WATCHDOG_EN and WDOG_LIMIT=16, hold wb_valid=0 after a commit at PC 0x8000_0010 -> halt_valid after 16 idle cycles; halt_code=0xFFFF_FFFF, halt_pc=0x8000_0010.

Source files
------------

// File: rtl/halt_pkg.sv
// Shared types and constants for the simulation halt handshake.
// The watchdog (HALT_WATCHDOG_EN) reuses WDOG_HALT_CODE from here.
package halt_pkg;

  localparam int unsigned CODE_W = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    REQ    = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [CODE_W-1:0] EBREAK_INST    = 32'h0010_0073;
  localparam logic [CODE_W-1:0] WDOG_HALT_CODE = 32'hFFFF_FFFF;

endpackage

// File: rtl/halt_watchdog.sv
// Idle-commit watchdog: counts RUN cycles without a commit and flags expiry.
// Only instantiated when HALT_WATCHDOG_EN is defined.
module halt_watchdog #(
  parameter int unsigned WDOG_LIMIT = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic wb_valid,
  output logic expire_c
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WDOG_LIMIT - 1);

  logic [CNT_W-1:0] count;

  // Any commit (or leaving RUN) restarts the idle count; saturate at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (!run || wb_valid) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire_c = run && !wb_valid && (count == LAST);

endmodule

// File: rtl/halt_ctrl.sv
// Halt handshake producer: stalls on a committed ebreak, drains memory
// traffic, then offers a valid/ready halt request. Optional HALT_WATCHDOG_EN.
module halt_ctrl
  import halt_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned WDOG_LIMIT   = 100000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wb_valid,
  input  logic [CODE_W-1:0]   wb_inst,
  input  logic [XLEN-1:0]     wb_pc,
  input  logic [XLEN-1:0]     R10,
  input  logic                lsu_busy,
  output logic                stall_o,
  output logic                halt_valid,
  input  logic                halt_ready,
  output logic [CODE_W-1:0]   halt_code,
  output logic [XLEN-1:0]     halt_pc,
  output logic                halted
);

  // The commit cycle itself counts as the first drain cycle.
  localparam int unsigned CNT_INIT = (DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1;
  localparam int unsigned CNT_W    = (CNT_INIT == 0) ? 1 : $clog2(CNT_INIT + 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ebreak_hit;
  logic             cap_ebreak;
  logic             cap_wdog;
  logic             wdog_expire;
  logic [XLEN-1:0]  last_pc;
  logic             unused_ok;

  assign unused_ok = ^{R10[XLEN-1:CODE_W], (WDOG_LIMIT == 0)};

`ifdef HALT_WATCHDOG_EN
  halt_watchdog #(
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clock    (clock),
    .reset    (reset),
    .run      (state == RUN),
    .wb_valid (wb_valid),
    .expire_c (wdog_expire)
  );

  // PC reported on a watchdog halt.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_pc <= '0;
    end else if (wb_valid && state == RUN) begin
      last_pc <= wb_pc;
    end
  end
`else
  assign wdog_expire = 1'b0;
  assign last_pc     = '0;
`endif

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    stall_o    = 1'b1;
    cap_ebreak = 1'b0;
    cap_wdog   = 1'b0;
    ebreak_hit = wb_valid && (wb_inst == EBREAK_INST) && (state == RUN);
    case (state)
      RUN: begin
        stall_o = ebreak_hit;
        if (ebreak_hit) begin
          cap_ebreak = 1'b1;
          cnt_nx     = CNT_W'(CNT_INIT);
          state_nx   = (DRAIN_CYCLES == 0 && !lsu_busy) ? REQ : DRAIN;
        end else if (wdog_expire) begin
          cap_wdog = 1'b1;
          state_nx = REQ;
        end
      end
      DRAIN: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end else if (!lsu_busy) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        if (halt_ready) state_nx = HALTED;
      end
      HALTED: state_nx = HALTED;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      cnt        <= '0;
      halt_valid <= 1'b0;
      halted     <= 1'b0;
      halt_code  <= '0;
      halt_pc    <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      halt_valid <= (state_nx == REQ);
      halted     <= (state_nx == HALTED);
      if (cap_ebreak) begin
        halt_code <= R10[CODE_W-1:0];
        halt_pc   <= wb_pc;
      end else if (cap_wdog) begin
        halt_code <= WDOG_HALT_CODE;
        halt_pc   <= last_pc;
      end
    end
  end

endmodule
